// File: rtl/mmu_seq_pkg.sv
// mmu_seq_pkg
// Shared definitions for the N x N matrix-multiply sequencer:
//   - state_t    : top-level sequencer states (IDLE, LOAD, COMPUTE, DRAIN)
//   - BYTE_W     : width of one host byte
//   - clog2_w    : ceil(log2(value)), used for address/counter widths
//   - clog2_min1 : same, but never below 1 (for indices that may need 0 bits)
package mmu_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    function automatic int clog2_w(input int value);
        return $clog2(value);
    endfunction

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/result_serializer.sv
// result_serializer
// Captures the array results on a one-cycle snapshot strobe and streams them
// to the host one byte at a time with valid/ready handshaking.
// Results are sent row-major; each result is sent most significant byte first.
//
// Optional build macro: MMU_SEQ_OUT_SAT_EN
//   When defined, each result is clamped to signed 8 bits and only one byte
//   per result is sent.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   snap        : capture c_flat and begin streaming (one-cycle strobe)
//   c_flat      : N*N results of ACC_W bits, row-major, c(0,0) in the LSBs
//   out_ready   : host accepts the current byte
//   out_data    : current byte (zero when nothing is being streamed)
//   out_valid   : a byte is being presented
//   out_last    : the presented byte is the final one of the set
module result_serializer
    import mmu_seq_pkg::*;
#(
    parameter int N     = 2,
    parameter int ACC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snap,
    input  logic [N*N*ACC_W-1:0]   c_flat,
    input  logic                   out_ready,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   out_last
);

    localparam int NB = ACC_W / BYTE_W;
`ifdef MMU_SEQ_OUT_SAT_EN
    localparam int BYTES_PER_RES = 1;
`else
    localparam int BYTES_PER_RES = NB;
`endif
    localparam int NBYTES = N * N * BYTES_PER_RES;
    localparam int CW     = clog2_w(N * N * NB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    logic [N*N*ACC_W-1:0] snap_q, snap_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [BYTE_W-1:0]    byte_arr [NBYTES];
    logic [BYTE_W-1:0]    byte_sel;

    // Lay the snapshot out as a flat list of bytes in transmission order so
    // the byte counter can index it directly.
    for (genvar r = 0; r < N * N; r++) begin : g_res
        logic [ACC_W-1:0] res;
        assign res = snap_q[r*ACC_W +: ACC_W];
`ifdef MMU_SEQ_OUT_SAT_EN
        // A result fits in signed 8 bits exactly when every bit from bit 7
        // upward is a copy of the sign.
        logic in_range;
        assign in_range = (res[ACC_W-1:BYTE_W-1] == '0) ||
                          (res[ACC_W-1:BYTE_W-1] == '1);
        assign byte_arr[r] = in_range      ? res[BYTE_W-1:0] :
                             res[ACC_W-1]  ? 8'h80 : 8'h7F;
`else
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign byte_arr[r*NB + b] = res[(NB-1-b)*BYTE_W +: BYTE_W];
        end
`endif
    end

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
                byte_sel = byte_arr[i];
            end
        end
    end

    // A new snapshot always restarts the stream; otherwise advance on each
    // accepted byte and stop after the last one.
    always_comb begin
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (snap) begin
            snap_d  = c_flat;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = valid_q && (cnt_q == CNT_LAST);
    assign out_data  = valid_q ? byte_sel : '0;

endmodule

// File: rtl/mmu_sequencer.sv
// mmu_sequencer
// Start/done driven sequencer for an N x N systolic matrix multiply.
// Phases: host byte load into operand memory, skewed operand feed into the
// array, then byte-serial drain of the results with valid/ready backpressure.
//
// Optional build macro: MMU_SEQ_OUT_SAT_EN (saturated one-byte-per-result
// drain, handled inside result_serializer).
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin an operation (only acted on in IDLE)
//   transpose      : B-operand transpose request, captured with start
//   load_valid     : host byte present on the memory write path
//   load_ready     : high for the whole LOAD phase
//   mem_addr       : operand memory write address
//   clear          : PE accumulator clear (first compute step)
//   feed_en        : per-lane feed enable, [N-1:0] A rows, [2N-1:N] B columns
//   feed_idx       : per-lane k index, lane i in bits [i*KW +: KW]
//   transpose_out  : captured transpose flag
//   c_flat         : array results, row-major, c(0,0) in the LSBs
//   out_data/out_valid/out_ready/out_last : result byte stream
//   busy           : sequencer not idle
//   done           : one-cycle pulse after the final byte is accepted
module mmu_sequencer
    import mmu_seq_pkg::*;
#(
    parameter int N     = 2,
    parameter int ACC_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              transpose,
    input  logic                              load_valid,
    output logic                              load_ready,
    output logic [clog2_w(2*N*N)-1:0]         mem_addr,
    output logic                              clear,
    output logic [2*N-1:0]                    feed_en,
    output logic [2*N*clog2_min1(N)-1:0]      feed_idx,
    output logic                              transpose_out,
    input  logic [N*N*ACC_W-1:0]              c_flat,
    output logic [BYTE_W-1:0]                 out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam int AW = clog2_w(2 * N * N);
    localparam int TW = clog2_w(3 * N);
    localparam int KW = clog2_min1(N);
    localparam logic [AW-1:0] ADDR_LAST = AW'(2 * N * N - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(3 * N - 3);

    state_t         state_q, state_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [TW-1:0]  t_q, t_d;
    logic           transpose_q, transpose_d;
    logic           done_q, done_d;
    logic           snap;
    logic           last_xfer;

    assign last_xfer = out_valid && out_ready && out_last;

    // Phase sequencing. The snapshot strobe fires on the final compute step
    // so the array is free to be reused while the results drain.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        t_d         = t_q;
        transpose_d = transpose_q;
        done_d      = 1'b0;
        snap        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    transpose_d = transpose;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    if (mem_addr_q == ADDR_LAST) begin
                        mem_addr_d = '0;
                        state_d    = COMPUTE;
                    end else begin
                        mem_addr_d = mem_addr_q + AW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = DRAIN;
                    snap    = 1'b1;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            t_q         <= '0;
            transpose_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            t_q         <= t_d;
            transpose_q <= transpose_d;
            done_q      <= done_d;
        end
    end

    // Skewed feed: lane i starts i steps late, so at step t it supplies
    // element k = t - i while that index is inside 0..N-1. A row i and
    // B column i share the same schedule.
    always_comb begin
        int k;
        k        = 0;
        feed_en  = '0;
        feed_idx = '0;
        clear    = 1'b0;
        if (state_q == COMPUTE) begin
            clear = (t_q == '0);
            for (int i = 0; i < N; i++) begin
                k = int'(t_q) - i;
                if ((k >= 0) && (k < N)) begin
                    feed_en[i]                    = 1'b1;
                    feed_en[N+i]                  = 1'b1;
                    feed_idx[i*KW +: KW]          = KW'(k);
                    feed_idx[(N+i)*KW +: KW]      = KW'(k);
                end
            end
        end
    end

    result_serializer #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .snap      (snap),
        .c_flat    (c_flat),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    assign load_ready    = (state_q == LOAD);
    assign busy          = (state_q != IDLE);
    assign mem_addr      = mem_addr_q;
    assign transpose_out = transpose_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer
// Directed bench for mmu_sequencer: an N=2/ACC_W=16 instance for load, drain,
// backpressure, illegal stimulus and reset, plus an N=3 instance for the
// feed schedule. Honours MMU_SEQ_OUT_SAT_EN for the expected byte stream.
`timescale 1ns/1ps
module tb_mmu_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=2 instance
    logic        start, transpose, load_valid, load_ready;
    logic [2:0]  mem_addr;
    logic        clear;
    logic [3:0]  feed_en;
    logic [3:0]  feed_idx;
    logic        transpose_out;
    logic [63:0] c_flat;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, out_last, busy, done;

    // N=3 instance
    logic         start3, transpose3, load_valid3, load_ready3;
    logic [4:0]   mem_addr3;
    logic         clear3;
    logic [5:0]   feed_en3;
    logic [11:0]  feed_idx3;
    logic         transpose_out3;
    logic [143:0] c_flat3;
    logic [7:0]   out_data3;
    logic         out_valid3, out_ready3, out_last3, busy3, done3;

    int n_checks;
    int n_fail;

`ifdef MMU_SEQ_OUT_SAT_EN
    localparam int          NBYTES     = 4;
    localparam logic [63:0] C_MAIN     = {16'h8000, 16'hFFF0, 16'hFF80, 16'h0123};
    localparam logic [63:0] EXP_STREAM = 64'h00000000_7F80F080;
`else
    localparam int          NBYTES     = 8;
    localparam logic [63:0] C_MAIN     = {16'hFF00, 16'h0001, 16'hABCD, 16'h1234};
    localparam logic [63:0] EXP_STREAM = 64'h1234ABCD_0001FF00;
`endif

    mmu_sequencer #(.N(2), .ACC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .transpose(transpose),
        .load_valid(load_valid), .load_ready(load_ready), .mem_addr(mem_addr),
        .clear(clear), .feed_en(feed_en), .feed_idx(feed_idx),
        .transpose_out(transpose_out), .c_flat(c_flat), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    mmu_sequencer #(.N(3), .ACC_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .transpose(transpose3),
        .load_valid(load_valid3), .load_ready(load_ready3), .mem_addr(mem_addr3),
        .clear(clear3), .feed_en(feed_en3), .feed_idx(feed_idx3),
        .transpose_out(transpose_out3), .c_flat(c_flat3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_last(out_last3),
        .busy(busy3), .done(done3)
    );

    // Expected byte j of the drained stream, first byte at the top of EXP_STREAM.
    function automatic logic [7:0] exp_byte(input int j);
        logic [63:0] s;
        s = EXP_STREAM;
        return s[(NBYTES-1-j)*8 +: 8];
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        load_valid  = 1'b0;
        out_ready   = 1'b0;
        start3      = 1'b0;
        load_valid3 = 1'b0;
        out_ready3  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // From IDLE: start, stream all load bytes, and return at the first
    // negedge where DRAIN presents its first byte.
    task automatic run_to_drain();
        int guard;
        guard = 0;
        @(negedge clk);
        start = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        load_valid = 1'b1;
        while (load_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        load_valid = 1'b0;
        while (!out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL run_to_drain_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        transpose   = 1'b0;
        load_valid  = 1'b0;
        out_ready   = 1'b0;
        c_flat      = '0;
        start3      = 1'b0;
        transpose3  = 1'b0;
        load_valid3 = 1'b0;
        out_ready3  = 1'b0;
        c_flat3     = '0;
        #1;
        n_checks++;
        if ({busy, done, load_ready, clear, transpose_out, out_valid, out_last} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b required 0000000",
                     {busy, done, load_ready, clear, transpose_out, out_valid, out_last});
        end
        n_checks++;
        if (mem_addr !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_addr: got %h required 0", mem_addr);
        end
        n_checks++;
        if ({feed_en, feed_idx} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_feed: got %h required 00", {feed_en, feed_idx});
        end
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_out_data: got %h required 00", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_idle_load_ignored();
        load_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, load_ready, mem_addr} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_load_ignored: got busy/ready/addr %b required 00000",
                     {busy, load_ready, mem_addr});
        end
        load_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_and_drain();
        logic [3:0] en_tab  [4] = '{4'b0101, 4'b1111, 4'b1010, 4'b0000};
        logic [3:0] idx_tab [4] = '{4'b0000, 4'b0101, 4'b1010, 4'b0000};
        logic       exp_last;
        c_flat    = C_MAIN;
        out_ready = 1'b0;
        // load_valid alongside start must not write a byte
        @(negedge clk);
        start      = 1'b1;
        transpose  = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        transpose = 1'b0;
        n_checks++;
        if ({busy, load_ready, transpose_out, mem_addr} !== 6'b111_000) begin
            n_fail++;
            $display("[TB] FAIL load_entry: busy/ready/tp/addr got %b required 111000",
                     {busy, load_ready, transpose_out, mem_addr});
        end
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            start = (k == 2);
            n_checks++;
            if (mem_addr !== 3'(k)) begin
                n_fail++;
                $display("[TB] FAIL load_addr_%0d: got %0d required %0d", k, mem_addr, k);
            end
            if (k == 4) begin
                load_valid = 1'b0;
                @(negedge clk);
                n_checks++;
                if (mem_addr !== 3'd4) begin
                    n_fail++;
                    $display("[TB] FAIL load_gap_hold: got %0d required 4", mem_addr);
                end
                load_valid = 1'b1;
            end
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start      = 1'b0;
            load_valid = 1'b0;
            n_checks++;
            if ({feed_en, feed_idx, clear} !== {en_tab[t], idx_tab[t], (t == 0)}) begin
                n_fail++;
                $display("[TB] FAIL feed_t%0d: en/idx/clear got %b_%b_%b required %b_%b_%b",
                         t, feed_en, feed_idx, clear, en_tab[t], idx_tab[t], (t == 0));
            end
            if (t == 0) begin
                n_checks++;
                if ({busy, load_ready, mem_addr} !== 5'b10_000) begin
                    n_fail++;
                    $display("[TB] FAIL compute_entry: busy/ready/addr got %b required 10000",
                             {busy, load_ready, mem_addr});
                end
            end
        end
        for (int j = 0; j < NBYTES; j++) begin
            @(negedge clk);
            if (j == 0) c_flat = ~C_MAIN;
            exp_last = (j == NBYTES - 1);
            n_checks++;
            if ({out_valid, out_last, done, out_data} !== {1'b1, exp_last, 1'b0, exp_byte(j)}) begin
                n_fail++;
                $display("[TB] FAIL drain_byte_%0d: valid/last/done/data got %b%b%b_%h required 1%b0_%h",
                         j, out_valid, out_last, done, out_data, exp_last, exp_byte(j));
            end
            out_ready = 1'b1;
            start     = (j == 1);
        end
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        n_checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL drain_done: done/busy/valid got %b required 100", {done, busy, out_valid});
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL done_one_cycle: done/busy got %b required 00", {done, busy});
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int         j;
        int         cyc;
        logic       exp_last;
        pat       = 4'b1001;
        j         = 0;
        cyc       = 0;
        c_flat    = C_MAIN;
        out_ready = 1'b0;
        run_to_drain();
        while (j < NBYTES && cyc < 64) begin
            exp_last = (j == NBYTES - 1);
            n_checks++;
            if ({out_valid, busy, out_last, out_data} !== {1'b1, 1'b1, exp_last, exp_byte(j)}) begin
                n_fail++;
                $display("[TB] FAIL bp_cycle_%0d: valid/busy/last/data got %b%b%b_%h required 11%b_%h",
                         cyc, out_valid, busy, out_last, out_data, exp_last, exp_byte(j));
            end
            out_ready = pat[cyc % 4];
            if (out_ready) j++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        n_checks++;
        if (j != NBYTES) begin
            n_fail++;
            $display("[TB] FAIL bp_timeout: transfers %0d required %0d", j, NBYTES);
        end
        n_checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL bp_done: done/busy/valid got %b required 100", {done, busy, out_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_start_on_done();
        int guard;
        guard  = 0;
        c_flat = C_MAIN;
        run_to_drain();
        out_ready = 1'b1;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if ({done, busy} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL done_wait: done/busy got %b required 10", {done, busy});
        end
        out_ready = 1'b0;
        start     = 1'b1;
        transpose = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, load_ready, transpose_out, mem_addr} !== 6'b110_000) begin
            n_fail++;
            $display("[TB] FAIL start_on_done: busy/ready/tp/addr got %b required 110000",
                     {busy, load_ready, transpose_out, mem_addr});
        end
    endtask

    task automatic test_reset_mid_drain();
        c_flat = C_MAIN;
        run_to_drain();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_data !== exp_byte(3)) begin
            n_fail++;
            $display("[TB] FAIL mid_drain_byte3: got %h required %h", out_data, exp_byte(3));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_last, busy, load_ready, done, out_data, mem_addr} !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL async_reset_outputs: got %h required 0000",
                     {out_valid, out_last, busy, load_ready, done, out_data, mem_addr});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL no_done_after_reset_%0d: done/busy got %b required 00", c, {done, busy});
            end
        end
    endtask

    task automatic test_feed_n3();
        int guard;
        guard = 0;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3      = 1'b0;
        load_valid3 = 1'b1;
        while (load_ready3 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        load_valid3 = 1'b0;
        // t = 0
        n_checks++;
        if ({feed_en3, clear3, feed_idx3} !== {6'b001001, 1'b1, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL n3_t0: en/clear/idx got %b_%b_%h required 001001_1_000",
                     feed_en3, clear3, feed_idx3);
        end
        repeat (2) @(negedge clk);
        // t = 2
        n_checks++;
        if ({feed_en3, clear3, feed_idx3} !== {6'b111111, 1'b0, 12'h186}) begin
            n_fail++;
            $display("[TB] FAIL n3_t2: en/clear/idx got %b_%b_%h required 111111_0_186",
                     feed_en3, clear3, feed_idx3);
        end
        @(negedge clk);
        // t = 3
        n_checks++;
        if ({feed_en3, feed_idx3} !== {6'b110110, 12'h618}) begin
            n_fail++;
            $display("[TB] FAIL n3_t3: en/idx got %b_%h required 110110_618", feed_en3, feed_idx3);
        end
        repeat (3) @(negedge clk);
        // t = 6, final compute step
        n_checks++;
        if ({busy3, out_valid3, feed_en3} !== {1'b1, 1'b0, 6'b000000}) begin
            n_fail++;
            $display("[TB] FAIL n3_t6: busy/valid/en got %b%b_%b required 10_000000",
                     busy3, out_valid3, feed_en3);
        end
        @(negedge clk);
        n_checks++;
        if ({busy3, out_valid3} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL n3_drain_entry: busy/valid got %b required 11", {busy3, out_valid3});
        end
        out_ready3 = 1'b1;
        guard      = 0;
        while (!done3 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        out_ready3 = 1'b0;
        n_checks++;
        if (guard != 18) begin
            n_fail++;
            $display("[TB] FAIL n3_drain_length: cycles to done %0d required 18", guard);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_idle_load_ignored();
        test_load_and_drain();
        test_backpressure();
        test_start_on_done();
        do_reset();
        test_reset_mid_drain();
        test_feed_n3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
